// File: rtl/glyph_streamer_pkg.sv
// glyph_streamer_pkg: shared FSM encoding, geometry defaults and control codes for glyph_streamer
package glyph_streamer_pkg;
  typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;
  localparam int GLYPH_W = 6;
  localparam int COLS = 21;
  localparam int PAGES = 8;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_QM = 8'h3F;
  function automatic logic [7:0] glyph_code(input logic [7:0] c);
    return (c >= 8'h20 && c <= 8'h7E) ? c : CH_QM;
  endfunction
endpackage

// File: rtl/glyph_streamer.sv
// glyph_streamer: turns character codes into font-ROM column bytes while tracking a text cursor
module glyph_streamer #(
  parameter int GLYPH_W = glyph_streamer_pkg::GLYPH_W,
  parameter int COLS = glyph_streamer_pkg::COLS,
  parameter int PAGES = glyph_streamer_pkg::PAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  input  logic       invert,
  input  logic       home,
  output logic       rom_rd,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       px_valid,
  output logic [7:0] px_data,
  output logic [6:0] px_x,
  output logic [2:0] px_page,
  output logic       px_last,
  input  logic       px_ready,
  output logic       busy
);
  import glyph_streamer_pkg::*;
  localparam int CW = $clog2(GLYPH_W + 1);
  localparam int XW = $clog2(COLS + 1);
  state_t state_q, state_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic [XW-1:0] cur_col_q, cur_col_d, col_h;
  logic [2:0] cur_page_q, cur_page_d, page_h, page_n;
  logic [9:0] base_q, base_d;
  logic [7:0] px_data_q, px_data_d;
  logic inv_q, inv_d, home_q, home_d, last, wrap;
  always_comb begin
    last = col_idx_q == CW'(GLYPH_W - 1);
    wrap = cur_col_q == XW'(COLS - 1);
    col_h = home ? '0 : cur_col_q;
    page_h = home ? '0 : cur_page_q;
    page_n = page_h == 3'(PAGES - 1) ? '0 : page_h + 3'd1;
    state_d = state_q;
    col_idx_d = col_idx_q;
    cur_col_d = cur_col_q;
    cur_page_d = cur_page_q;
    base_d = base_q;
    inv_d = inv_q;
    px_data_d = px_data_q;
    home_d = home_q | (home && state_q != IDLE);
    case (state_q)
      IDLE: begin
        cur_col_d = col_h;
        cur_page_d = page_h;
        if (ch_valid && (ch_data == CH_LF || ch_data == CH_CR)) begin
          cur_col_d = '0;
          cur_page_d = ch_data == CH_LF ? page_n : page_h;
        end else if (ch_valid) begin
          state_d = READ;
          col_idx_d = '0;
          base_d = 10'(int'(glyph_code(ch_data)) * GLYPH_W);
          inv_d = invert;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        px_data_d = rom_data ^ {8{inv_q}};
        state_d = SEND;
      end
      default: if (px_ready) begin
        state_d = last ? IDLE : READ;
        col_idx_d = last ? '0 : col_idx_q + 1'b1;
        if (last) begin
          // a home seen during the glyph overrides the normal cursor advance
          home_d = 1'b0;
          cur_col_d = (home_q || home || wrap) ? '0 : cur_col_q + 1'b1;
          cur_page_d = (home_q || home) ? '0 : wrap ? page_n : cur_page_q;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_idx_q <= '0;
      cur_col_q <= '0;
      cur_page_q <= '0;
      base_q <= '0;
      px_data_q <= '0;
      inv_q <= 1'b0;
      home_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_idx_q <= col_idx_d;
      cur_col_q <= cur_col_d;
      cur_page_q <= cur_page_d;
      base_q <= base_d;
      px_data_q <= px_data_d;
      inv_q <= inv_d;
      home_q <= home_d;
    end
  end
  assign ch_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign rom_rd = state_q == READ;
  assign rom_addr = rom_rd ? base_q + 10'(col_idx_q) : '0;
  assign px_valid = state_q == SEND;
  assign px_data = px_data_q;
  assign px_x = 7'(int'(cur_col_q) * GLYPH_W + int'(col_idx_q));
  assign px_page = cur_page_q;
  assign px_last = px_valid && last;
endmodule

// File: tb/tb_glyph_streamer.sv
// tb_glyph_streamer: randomized scoreboard bench with a cursor-level reference model of glyph_streamer
module tb_glyph_streamer;
  logic clk = 0, rst = 1, ch_valid = 0, invert = 0, home = 0, px_ready = 1;
  logic [7:0] ch_data = 0, rom_data = 0;
  logic ch_ready, rom_rd, px_valid, px_last, busy;
  logic [9:0] rom_addr;
  logic [7:0] px_data;
  logic [6:0] px_x;
  logic [2:0] px_page;
  logic [7:0] rom [1024];
  typedef struct {logic [7:0] d; logic [6:0] x; logic [2:0] p; logic l;} px_t;
  px_t exp_q[$];
  int addr_q[$];
  px_t hold, mon_e;
  logic held = 0;
  int tests = 0, fails = 0, mcol = 0, mpage = 0;
  int rdy_mode = 0;
  logic rdy_fix = 1;

  glyph_streamer dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .invert(invert), .home(home), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .px_valid(px_valid), .px_data(px_data), .px_x(px_x), .px_page(px_page),
    .px_last(px_last), .px_ready(px_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);

  // font ROM beside the block: new byte on the falling edge of a read cycle
  always @(negedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  initial forever begin
    @(posedge clk);
    #1;
    px_ready = rdy_mode != 0 ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  task automatic check(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic void model(input logic [7:0] c, input logic inv);
    int m;
    if (c == 8'h0A) begin
      mcol = 0;
      mpage = (mpage + 1) % 8;
      return;
    end
    if (c == 8'h0D) begin
      mcol = 0;
      return;
    end
    m = (c >= 8'h20 && c <= 8'h7E) ? int'(c) : 'h3F;
    for (int i = 0; i < 6; i++) begin
      addr_q.push_back(m * 6 + i);
      exp_q.push_back('{rom[m * 6 + i] ^ (inv ? 8'hFF : 8'h00), 7'(mcol * 6 + i), 3'(mpage), i == 5});
    end
    mcol++;
    if (mcol == 21) begin
      mcol = 0;
      mpage = (mpage + 1) % 8;
    end
  endfunction

  always @(negedge clk) if (!rst) begin
    if (rom_rd) begin
      if (addr_q.size() == 0) check("rom_rd_unexpected", 1, 0);
      else check("rom_addr", int'(rom_addr), addr_q.pop_front());
    end
    if (px_valid) begin
      if (held) begin
        check("hold_data", int'(px_data), int'(hold.d));
        check("hold_x", int'(px_x), int'(hold.x));
        check("hold_page", int'(px_page), int'(hold.p));
        check("hold_last", int'(px_last), int'(hold.l));
      end
      if (px_ready) begin
        held = 0;
        if (exp_q.size() == 0) check("px_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("px_data", int'(px_data), int'(mon_e.d));
          check("px_x", int'(px_x), int'(mon_e.x));
          check("px_page", int'(px_page), int'(mon_e.p));
          check("px_last", int'(px_last), int'(mon_e.l));
        end
      end else if (!held) begin
        held = 1;
        hold = '{px_data, px_x, px_page, px_last};
      end
    end else held = 0;
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [7:0] c, input logic inv, input logic hm);
    int n = 0;
    ch_valid = 1;
    ch_data = c;
    invert = inv;
    home = hm;
    if (hm) begin
      mcol = 0;
      mpage = 0;
    end
    model(c, inv);
    @(negedge clk);
    while (!ch_ready && n < 400) begin
      @(posedge clk);
      #1 home = 0;
      @(negedge clk);
      n++;
    end
    if (!ch_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    ch_valid = 0;
    home = 0;
  endtask

  task automatic wait_idle;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || !ch_ready) && n < 4000);
    if (n >= 4000) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, r;
    logic [7:0] c;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ch_ready", int'(ch_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_rom_rd", int'(rom_rd), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_px_valid", int'(px_valid), 0);
    check("rst_px_data", int'(px_data), 0);
    check("rst_px_x", int'(px_x), 0);
    check("rst_px_page", int'(px_page), 0);
    check("rst_px_last", int'(px_last), 0);
    @(posedge clk);
    #1 rst = 0;

    send(8'h41, 0, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!px_valid && n < 20);
    check("latency", n, 3);
    n = 0;
    do begin @(negedge clk); n++; end while (!px_valid && n < 20);
    check("col_period", n, 3);
    wait_idle;
    send(8'h41, 1, 0);
    wait_idle;

    send(8'h0D, 0, 1);
    repeat (21) send(8'h23, 0, 0);
    send(8'h42, 0, 0);
    wait_idle;
    send(8'h0D, 0, 1);
    repeat (7) send(8'h0A, 0, 0);
    repeat (5) send(8'h78, 0, 0);
    send(8'h0A, 0, 0);
    send(8'h5A, 0, 0);
    wait_idle;

    rdy_fix = 0;
    send(8'h47, 1, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!px_valid && n < 20);
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", int'(px_valid), 1);
      check("stall_rom_rd", int'(rom_rd), 0);
    end
    rdy_fix = 1;
    wait_idle;

    send(8'h80, 0, 0);
    wait_idle;

    send(8'h43, 0, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(px_valid && px_x == 7'd3) && n < 40);
    #1 rst = 1;
    @(negedge clk);
    check("abort_px_valid", int'(px_valid), 0);
    check("abort_ch_ready", int'(ch_ready), 1);
    check("abort_busy", int'(busy), 0);
    exp_q.delete();
    addr_q.delete();
    mcol = 0;
    mpage = 0;
    held = 0;
    @(posedge clk);
    #1 rst = 0;
    send(8'h44, 0, 0);
    wait_idle;

    rdy_mode = 1;
    repeat (250) begin
      r = $urandom_range(0, 9);
      c = r == 0 ? 8'h0A : r == 1 ? 8'h0D : r == 2 ? 8'($urandom_range(128, 255)) :
          r == 3 ? 8'($urandom_range(0, 31)) : 8'($urandom_range(32, 126));
      send(c, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle;
    check("queues_empty", exp_q.size() + addr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d failures", fails);
    $fatal(1);
  end
endmodule

// File: doc/glyph_streamer.md
GLYPH_STREAMER -- requirements
Module: glyph_streamer

Interface
REQ-001 SHALL have parameter GLYPH_W, default 6, meaning the number of pixel columns (ROM bytes) per glyph.
REQ-002 SHALL have parameter COLS, default 21, meaning the number of character cells per text line.
REQ-003 SHALL have parameter PAGES, default 8, meaning the number of 8-pixel text lines (pages).
REQ-004 SHALL have port clk  in  1  system clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port ch_valid  in  1  character byte offered.
REQ-007 SHALL have port ch_data  in  8  character code.
REQ-008 SHALL have port ch_ready  out  1  character accepted when ch_valid and ch_ready are both high at a rising edge.
REQ-009 SHALL have port invert  in  1  inverse video, sampled at character accept.
REQ-010 SHALL have port home  in  1  single-cycle pulse that sets the cursor to column 0, page 0.
REQ-011 SHALL have port rom_rd  out  1  font ROM read enable.
REQ-012 SHALL have port rom_addr  out  10  font ROM byte address.
REQ-013 SHALL have port rom_data  in  8  font ROM byte, updated on the falling clock edge when rom_rd is high, held otherwise.
REQ-014 SHALL have port px_valid  out  1  column byte offered downstream.
REQ-015 SHALL have port px_data  out  8  pixel column, LSB = top pixel.
REQ-016 SHALL have port px_x  out  7  pixel column address.
REQ-017 SHALL have port px_page  out  3  page address.
REQ-018 SHALL have port px_last  out  1  high on the final column of a glyph.
REQ-019 SHALL have port px_ready  in  1  downstream accepts the byte when px_valid and px_ready are both high at a rising edge.
REQ-020 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement the FSM IDLE -> READ -> CAPT -> SEND -> (READ if col_idx<GLYPH_W-1, else IDLE).
REQ-022 ch_ready SHALL be high only in IDLE.
REQ-023 Printable codes 0x20-0x7E SHALL produce glyph_base = code*GLYPH_W; codes >= 0x7F and 0x00-0x1F other than 0x0A/0x0D SHALL use code 0x3F ('?').
REQ-024 On 0x0A, cursor SHALL become column 0 with page+1 (mod PAGES); on 0x0D, cursor SHALL become column 0 with page unchanged; in both cases no bytes are emitted and the FSM stays in IDLE.
REQ-025 In READ, rom_rd SHALL be high for exactly one cycle with rom_addr = glyph_base + col_idx; rom_rd SHALL be low in all other states.
REQ-026 In CAPT, rom_data SHALL be registered into px_data, XORed with 0xFF when the latched invert is 1.
REQ-027 In SEND, px_valid SHALL be high with px_x = cur_col*GLYPH_W + col_idx, px_page = cur_page, and px_last = (col_idx == GLYPH_W-1).
REQ-028 px_data, px_x, px_page and px_last SHALL stay stable while px_valid is high and px_ready is low.
REQ-029 When the final column is accepted, cur_col SHALL increment; at COLS-1 it SHALL wrap to 0 and page SHALL increment mod PAGES.
REQ-030 Per-character latency from accept to first px_valid SHALL be 3 cycles, with one column per 3 cycles when px_ready is held high.
REQ-031 A home pulse SHALL take effect immediately in IDLE; outside IDLE it SHALL be held pending and applied after the current glyph completes.
REQ-032 If home and a character accept occur in the same IDLE cycle, home SHALL apply first and the character SHALL print at (0,0).

Reset
REQ-033 On rst the block SHALL enter IDLE and clear cur_col, cur_page, col_idx and pending home, driving rom_rd=0, rom_addr=0, px_valid=0, px_data=0, px_x=0, px_page=0, px_last=0, busy=0, ch_ready=1 on the following cycle.
REQ-034 A reset asserted mid-glyph SHALL abort the glyph with no further px_valid.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, GLYPH_W, COLS, PAGES and the constants 0x0A, 0x0D and 0x3F.
REQ-036 The block SHALL be a single module with no sub-modules; the font ROM is instantiated beside it at the next level up.

Verification
REQ-037 Send 'A' (0x41) with px_ready=1: rom_addr 390..395 and six bytes px_x 0..5, page 0, px_last only on x=5.
REQ-038 Send 'A' with invert=1: each px_data equals the ROM byte XOR 0xFF.
REQ-039 Send 21 '#' then 'B': the 22nd glyph appears at px_x 0..5, page 1; 0x0A at cursor (5,7) gives cursor (0,0).
REQ-040 Hold px_ready low for 10 cycles during SEND: px outputs stay stable, rom_rd stays 0, and the sequence resumes correctly.
REQ-041 Send 0x80: bytes match glyph '?' (addresses 378..383).
REQ-042 Assert rst during column 3: px_valid=0 the next cycle, ch_ready=1, and the next character prints at (0,0).
